cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

- Shares the common data bus (CDB) between the result-producing units: ALU, memory functional unit and MMU return path.
- Replaces fixed-priority CDB selection with round-robin arbitration, so no unit can starve another.
- Registers the winning result into a single broadcast slot that the ROB and reservation stations consume.
- Supports consumer back-pressure and flush on branch miss.

## Interface
Parameters:
- N_UNITS, 3: number of requesting units; must be ≥ 2.
- CDB_W, fcpu_pkg::CDB_W: CDB word width, laid out as {rsv_id[RSV_ID_W], data[DATA_W]}.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  branch-miss flush; discards the slot and blocks grants this cycle.
- i_cdb  in  N_UNITS×CDB_W  per-unit result word.
- i_valid  in  N_UNITS  per-unit result valid.
- i_ready  out  N_UNITS  per-unit grant; a transfer occurs on i_valid[k] & i_ready[k].
- o_cdb  out  CDB_W  broadcast word, registered.
- o_valid  out  1  broadcast valid, registered.
- o_grant_id  out  $clog2(N_UNITS)  index of the unit that produced o_cdb, registered.
- o_ready  in  1  consumer accepts the broadcast (ROB/stations not stalled).

## Operation
- Single output slot, with accept = ~o_valid | o_ready.
- Arbitration:
  - Scan i_valid starting at rr_ptr, wrapping modulo N_UNITS.
  - The first asserted index is the winner w.
  - i_ready[w] = accept & ~flush & ~rst; all other i_ready bits are 0.
  - i_ready is combinational from i_valid, rr_ptr, o_valid, o_ready, flush and rst.
  - i_ready never asserts for a unit whose i_valid is low.
- On grant:
  - o_cdb ← i_cdb[w], o_grant_id ← w, o_valid ← 1.
  - rr_ptr ← (w+1) mod N_UNITS; wrap from N_UNITS-1 goes to 0.
- No grant while accept = 1: o_valid ← 0; o_cdb and o_grant_id hold their last value; rr_ptr holds.
- accept = 0 (slot full, o_ready low): slot holds, no grant, rr_ptr holds.
- Flush has priority over everything except rst:
  - o_valid ← 0, no grant, rr_ptr holds.
  - o_cdb and o_grant_id are don't-care after flush.
- Reset:
  - rr_ptr = 0, o_valid = 0, o_cdb = 0, o_grant_id = 0.
  - i_ready = 0 while rst is high.
  - Reset mid-transfer drops the slot contents. Units must re-present after reset; a grant is never issued during rst.
- Simultaneous o_ready and new grant: the old word retires and the new word loads in the same edge (full throughput, one result per cycle).
- Units must hold i_cdb and i_valid stable until granted. The arbiter does not check this.

## Timing
- Latency: grant in cycle t, so o_valid and o_cdb are visible in cycle t+1.
- Throughput: 1 result/cycle while o_ready = 1.
- Fairness: a unit holding i_valid high is granted within N_UNITS grants. Worst case is N_UNITS cycles with o_ready tied high.
- Output stalls: o_valid, o_cdb and o_grant_id stay constant while o_valid & ~o_ready & ~flush.
- No combinational path from i_cdb to o_cdb.

## Structure
- fcpu_pkg holds CDB_W, RSV_ID_W, DATA_W and a cdb_t packed struct {rsv_id, data}. No new package constants are needed.
- Sub-module rr_arbiter:
  - Parameter N, ports req[N], en, gnt[N] (one-hot), gnt_idx, and the registered pointer.
  - Pointer advances only when en & |req.
  - Reusable for the reservation-station issue select.
- cdb_arbiter contains the output slot register, the accept/flush logic, and one rr_arbiter instance.

## Test plan
- **Reset.** Hold rst 2 cycles with all i_valid = 1.
  - Expect i_ready = 000, o_valid = 0, o_cdb = 0, o_grant_id = 0.
  - In the first cycle after reset, i_ready = 001.
- **Rotation.** All three units valid continuously with words 0x…A0/0x…B1/0x…C2 and o_ready = 1.
  - Expect o_grant_id sequence 0,1,2,0,1,2 and o_valid high every cycle.
- **Back-pressure.** Unit 1 presents 0x1234 with o_ready = 0 for 3 cycles.
  - Expect o_valid = 1 and o_cdb = 0x1234 held.
  - i_ready = 000 for those 3 cycles; rr_ptr unchanged.
  - Raise o_ready: the next grant goes to unit 2 if it is valid.
- **Flush.** Slot holds a unit-0 result while flush rises and unit 2 is valid.
  - Next cycle o_valid = 0 and no i_ready is asserted.
  - The cycle after flush falls, unit 2 is granted.
- **Wrap and skip.** rr_ptr = 2 with only unit 1 valid.
  - Expect unit 1 granted, then rr_ptr = 2.
  - Then only unit 2 valid: granted, rr_ptr wraps to 0.
- **Starvation bound.** Units 0 and 2 stream continuously while unit 1 raises i_valid at random cycles.
  - Expect unit 1 granted within ≤ 3 cycles every time.

Source files
------------

// File: rtl/fcpu_pkg.sv
// Shared core types: CDB word layout and widths.
package fcpu_pkg;

  localparam int RSV_ID_W = 4;
  localparam int DATA_W   = 32;
  localparam int CDB_W    = RSV_ID_W + DATA_W;

  typedef struct packed {
    logic [RSV_ID_W-1:0] rsv_id;
    logic [DATA_W-1:0]   data;
  } cdb_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request selector with a registered rotating pointer.
// Also meant for reuse as the reservation-station issue select.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic [$clog2(N)-1:0] ptr
);

  localparam int IW = $clog2(N);

  logic          hit;
  logic [IW-1:0] win;
  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Scan requests starting at ptr, wrapping modulo N; first hit wins.
  always_comb begin
    hit  = 1'b0;
    win  = '0;
    sum  = '0;
    cand = '0;
    for (int i = 0; i < N; i++) begin
      sum  = {1'b0, ptr} + (IW+1)'(i);
      cand = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
      if (!hit && req[cand]) begin
        hit = 1'b1;
        win = cand;
      end
    end
  end

  assign gnt     = (en && hit) ? (N'(1) << win) : '0;
  assign gnt_idx = win;

  // Pointer moves to one past the winner, only when a grant is issued.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (en && hit)
      ptr <= (win == IW'(N-1)) ? '0 : win + 1'b1;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin select among result units into one registered
// broadcast slot, with consumer back-pressure and branch-miss flush.
module cdb_arbiter
  import fcpu_pkg::*;
#(
  parameter int N_UNITS = 3,
  parameter int CDB_W   = fcpu_pkg::CDB_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [N_UNITS-1:0][CDB_W-1:0]    i_cdb,
  input  logic [N_UNITS-1:0]               i_valid,
  output logic [N_UNITS-1:0]               i_ready,
  output logic [CDB_W-1:0]                 o_cdb,
  output logic                             o_valid,
  output logic [$clog2(N_UNITS)-1:0]       o_grant_id,
  input  logic                             o_ready
);

  localparam int IDW = $clog2(N_UNITS);

  logic           accept;
  logic           en;
  logic [N_UNITS-1:0] gnt;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] rr_ptr;

  // Slot can take a new word when empty or when the current one retires.
  assign accept  = ~o_valid | o_ready;
  assign en      = accept & ~flush & ~rst;
  assign i_ready = gnt;

  rr_arbiter #(.N(N_UNITS)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (i_valid),
    .en      (en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .ptr     (rr_ptr)
  );

  // Broadcast slot: flush empties it, otherwise load the winner or drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o_cdb      <= '0;
      o_grant_id <= '0;
    end else if (flush) begin
      o_valid <= 1'b0;
    end else if (accept) begin
      o_valid <= |gnt;
      if (|gnt) begin
        o_cdb      <= i_cdb[gnt_idx];
        o_grant_id <= gnt_idx;
      end
    end
  end

  // A live broadcast always came from the unit just behind the pointer.
  always_ff @(posedge clk) begin
    if (!rst && o_valid)
      assert (rr_ptr == ((o_grant_id == IDW'(N_UNITS-1)) ? '0 : o_grant_id + 1'b1))
        else $error("rr_ptr out of step with o_grant_id");
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: behavioural slot/pointer model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_cdb_arbiter;
  import fcpu_pkg::*;

  localparam int N = 3;
  localparam int W = fcpu_pkg::CDB_W;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                flush = 1'b0;
  logic                o_ready = 1'b1;
  logic [N-1:0][W-1:0] i_cdb;
  logic [N-1:0]        i_valid;
  logic [N-1:0]        i_ready;
  logic [W-1:0]        o_cdb;
  logic                o_valid;
  logic [1:0]          o_grant_id;

  cdb_arbiter #(.N_UNITS(N), .CDB_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .i_cdb      (i_cdb),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .o_cdb      (o_cdb),
    .o_valid    (o_valid),
    .o_grant_id (o_grant_id),
    .o_ready    (o_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // unit side: pending request, held word, re-present after grant
  bit         pend[N];
  logic [W-1:0] word[N];
  bit         keep[N];

  // model of the broadcast slot and rotation pointer
  int         m_ptr;
  bit         m_ov;
  logic [W-1:0] m_cdb;
  int         m_id;
  bit         m_dc;      // slot contents undefined (after flush / before reset)
  int         last_gnt;

  always_comb
    for (int k = 0; k < N; k++) begin
      i_valid[k] = pend[k];
      i_cdb[k]   = word[k];
    end

  function automatic int winner();
    if (rst || flush || (m_ov && !o_ready)) return -1;
    for (int d = 0; d < N; d++)
      if (pend[(m_ptr + d) % N]) return (m_ptr + d) % N;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: compare DUT to model, then advance model on the edge.
  task automatic cyc();
    int w;
    logic [N-1:0] er;
    #1;
    w  = winner();
    er = (w >= 0) ? (N'(1) << w) : '0;
    chk("i_ready", 64'(i_ready), 64'(er));
    chk("o_valid", 64'(o_valid), 64'(m_ov));
    if (!m_dc) begin
      chk("o_cdb", 64'(o_cdb), 64'(m_cdb));
      chk("o_grant_id", 64'(o_grant_id), 64'(m_id));
    end
    @(posedge clk);
    #1;
    last_gnt = -1;
    if (rst) begin
      m_ptr = 0; m_ov = 1'b0; m_cdb = '0; m_id = 0; m_dc = 1'b0;
    end else if (flush) begin
      m_ov = 1'b0; m_dc = 1'b1;
    end else if (!m_ov || o_ready) begin
      if (w >= 0) begin
        m_ov = 1'b1; m_cdb = word[w]; m_id = w; m_dc = 1'b0;
        m_ptr = (w + 1) % N; last_gnt = w;
        if (!keep[w]) pend[w] = 1'b0;
      end else begin
        m_ov = 1'b0;
      end
    end
  endtask

  task automatic set_pend(input bit p0, input bit p1, input bit p2);
    pend[0] = p0; pend[1] = p1; pend[2] = p2;
  endtask

  int wait1;
  bit waiting;

  initial begin
    m_ptr = 0; m_ov = 1'b0; m_cdb = '0; m_id = 0; m_dc = 1'b1; last_gnt = -1;
    word[0] = W'(36'hA0); word[1] = W'(36'hB1); word[2] = W'(36'hC2);
    set_pend(1, 1, 1);
    for (int k = 0; k < N; k++) keep[k] = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    m_dc = 1'b0;

    // reset held with every unit requesting
    repeat (2) begin
      cyc();
      chk("rst_i_ready", 64'(i_ready), 64'h0);
      chk("rst_o_valid", 64'(o_valid), 64'h0);
      chk("rst_o_cdb", 64'(o_cdb), 64'h0);
      chk("rst_o_grant_id", 64'(o_grant_id), 64'h0);
    end
    rst = 1'b0;
    #1 chk("post_rst_ready", 64'(i_ready), 64'h1);

    // rotation under full throughput
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("rot_id", 64'(o_grant_id), 64'(k % 3));
      chk("rot_valid", 64'(o_valid), 64'h1);
    end

    // back-pressure: unit 1 word held while consumer stalls
    for (int k = 0; k < N; k++) keep[k] = 1'b0;
    set_pend(0, 1, 0); word[1] = W'(36'h1234);
    cyc();
    o_ready = 1'b0;
    set_pend(1, 0, 1); word[0] = W'(36'h0A0A); word[2] = W'(36'h2C2C);
    repeat (3) begin
      cyc();
      chk("bp_i_ready", 64'(i_ready), 64'h0);
      chk("bp_o_valid", 64'(o_valid), 64'h1);
      chk("bp_o_cdb", 64'(o_cdb), 64'h1234);
    end
    o_ready = 1'b1;
    #1 chk("bp_next_unit2", 64'(i_ready), 64'h4);
    cyc();
    cyc();                            // unit 0 now loads the slot
    chk("fl_slot_unit0", 64'(o_grant_id), 64'h0);

    // flush over a held unit-0 result with unit 2 waiting
    set_pend(0, 0, 1); word[2] = W'(36'hCC);
    o_ready = 1'b0; flush = 1'b1;
    #1 chk("fl_i_ready", 64'(i_ready), 64'h0);
    cyc();
    chk("fl_o_valid", 64'(o_valid), 64'h0);
    flush = 1'b0; o_ready = 1'b1;
    #1 chk("fl_after_ready", 64'(i_ready), 64'h4);
    cyc();
    chk("fl_after_id", 64'(o_grant_id), 64'h2);
    chk("fl_after_cdb", 64'(o_cdb), 64'hCC);

    // wrap and skip
    set_pend(0, 1, 0); cyc();          // pointer now 2
    set_pend(0, 1, 0);
    #1 chk("wrap_skip_u1", 64'(i_ready), 64'h2);
    cyc();
    set_pend(0, 0, 1);
    #1 chk("wrap_u2", 64'(i_ready), 64'h4);
    cyc();
    set_pend(1, 1, 1);
    #1 chk("wrap_to_0", 64'(i_ready), 64'h1);
    set_pend(0, 0, 0);
    cyc();

    // starvation bound: units 0 and 2 stream, unit 1 arrives at random
    keep[0] = 1'b1; keep[2] = 1'b1; keep[1] = 1'b0;
    set_pend(1, 0, 1);
    waiting = 1'b0; wait1 = 0;
    for (int c = 0; c < 300; c++) begin
      if (!waiting && $urandom_range(0, 3) == 0) begin
        pend[1] = 1'b1; word[1] = W'($urandom); waiting = 1'b1; wait1 = 0;
      end
      cyc();
      if (waiting) begin
        wait1++;
        if (last_gnt == 1) begin
          chk("starve_bound", 64'(wait1 <= N), 64'h1);
          waiting = 1'b0;
        end else if (wait1 > N + 2) begin
          chk("starve_timeout", 64'(wait1), 64'(N));
          pend[1] = 1'b0; waiting = 1'b0;
        end
      end
    end

    // random traffic with stalls, flushes and occasional reset
    for (int k = 0; k < N; k++) keep[k] = 1'b0;
    set_pend(0, 0, 0);
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < N; k++)
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1;
          word[k] = W'({$urandom, $urandom});
        end
      o_ready = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 63) == 0);
      cyc();
    end
    rst = 1'b0; flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
